l4_field_extractor: RTL and testbench
=====================================

# l4_field_extractor

Header parser stage placed directly upstream of the TCP/UDP classifier on the RX path. It watches a 64-bit Avalon-ST packet stream and handles up to two VLAN tags and either an IPv4 or an IPv6 header. From each packet it extracts the IP protocol (next-header) byte and the L4 source and destination ports. These are presented as registered fields with per-field enables, which feed the classifier's `ip_prot`, `port_src` and `port_dst` inputs directly. The block is a pure observer: it never backpressures and never modifies the stream.

## Interface
- `MAX_VLAN`, 2: number of stacked 802.1Q/802.1ad tags skipped (0..2).
- `clk_i` in 1: single clock for all logic.
- `rst_i` in 1: reset, synchronous, active-high.
- `snk_data_i` in 64: stream data; byte 0 of a beat on [63:56], network order.
- `snk_valid_i` in 1: beat qualifier; all other `snk_*` inputs are ignored when low.
- `snk_sop_i` in 1: first beat of a packet.
- `snk_eop_i` in 1: last beat of a packet.
- `snk_empty_i` in 3: number of invalid trailing bytes on the eop beat.
- `ip_prot_o` out 8: IPv4 protocol or IPv6 next header.
- `ip_prot_en_o` out 1: `ip_prot_o` is valid for the current packet.
- `port_src_o` out 16: L4 source port.
- `port_src_en_o` out 1: `port_src_o` is valid.
- `port_dst_o` out 16: L4 destination port.
- `port_dst_en_o` out 1: `port_dst_o` is valid.
- `ipv6_o` out 1: current packet is IPv6.
- `hdr_done_o` out 1: one-cycle pulse, once per packet, when parsing is finished.

## Operation
- Beat counter `beat_cnt` (4 bits):
  - cleared on a valid sop beat;
  - incremented on each subsequent valid beat;
  - saturates at 15.
- Absolute byte offset of a byte = 8*`beat_cnt` + lane.
- `l3_off` starts at 14 and is resolved from the tags:
  - TPID at offset 12 equal to 0x8100 or 0x88A8: `l3_off` = 18;
  - a second tag at offset 16 (only when `MAX_VLAN` = 2): `l3_off` = 22;
  - EtherType is always the two bytes at `l3_off`-2.
- Same-beat dependencies must be resolved lane-wise, with no extra beat of delay. Example: the second TPID (offsets 16-17) and the final EtherType (offsets 20-21) both arrive in beat 2.
- FSM states:
  - **IDLE**: waiting for sop.
  - **L2**: resolving `l3_off` and EtherType.
  - **IP4**: IPv4 header.
  - **IP6**: IPv6 header.
  - **L4**: waiting for the port bytes.
  - **DONE**: parsing finished; ignore beats until eop.
- Transitions:
  - Any valid sop beat → L2, from any state. A sop without a prior eop aborts the old packet with no `hdr_done_o` for it.
  - L2 → IP4 on EtherType 0x0800 with version nibble 4.
  - L2 → IP6 on EtherType 0x86DD with version nibble 6.
  - L2 → DONE on any other EtherType.
- IPv4 (IP4):
  - IHL = low nibble of byte `l3_off`; IHL < 5 means malformed → DONE with no enables.
  - Protocol is byte `l3_off`+9.
  - Fragment offset is the low 13 bits of `l3_off`+6..7. If non-zero, go to DONE after the protocol is captured, with no port enables.
  - Otherwise `l4_off` = `l3_off` + 4*IHL, an 8-bit sum (max 22+60 = 82).
- IPv6 (IP6):
  - Next header is byte `l3_off`+6.
  - `l4_off` = `l3_off`+40. Extension headers are not walked.
- Ports: captured only when the protocol is 6 (TCP), 17 (UDP) or 132 (SCTP).
  - `port_src_o` = bytes `l4_off`..+1.
  - `port_dst_o` = bytes `l4_off`+2..+3.
- Capturing a field sets its enable. Fields and enables hold until the next sop, which clears all enables in the same cycle the sop beat is accepted. Field values themselves are not cleared.
- Truncation: if eop arrives, or a byte falls inside `snk_empty_i`, before a field's last byte, that field's enable stays 0.
- Offsets beyond 8*15+7 are never reached; `beat_cnt` saturation must not produce false captures.

## Timing
- Reset values: every output is 0; the FSM is in IDLE.
- Each field register and its enable update on the clock edge ending the valid beat that carries the field's last byte. Latency is 1 cycle from that beat.
- `hdr_done_o` pulses on the first of these edges, once per packet:
  - the edge on which the final required field is captured;
  - the edge on which the FSM enters DONE without ports;
  - the eop edge.
- Invalid cycles (`snk_valid_i` = 0) freeze the FSM, counter and capture logic.
- Reset asserted mid-packet: outputs are 0 on the next edge, and beats are ignored until the next sop.
- Sop and eop on the same beat (single-beat packet) are legal: `hdr_done_o` pulses, all enables stay 0.

## Test plan
- Untagged IPv4 TCP, IHL=5, src 0x1F90, dst 0x0017. Required:
  - `ip_prot_o`=6 with its enable set one cycle after beat 2;
  - ports correct with enables set one cycle after beat 4;
  - single `hdr_done_o` pulse.
- Double-tagged (0x88A8, 0x8100) IPv4 UDP, IHL=7, dst 319. Required: `l3_off`=22, `l4_off`=50, `port_dst_o`=319, `ip_prot_o`=17.
- IPv6 UDP, dst 53. Required: `ipv6_o`=1, `ip_prot_o`=17, `port_dst_o`=53.
- IPv4 fragment (offset 0x00B9), protocol 17. Required: `ip_prot_en_o`=1, both port enables 0, `hdr_done_o` pulse.
- ARP (EtherType 0x0806), then a 30-byte IPv4 packet truncated by eop. Required:
  - ARP: no enables, `hdr_done_o` pulse;
  - truncated packet: protocol captured, port enables 0.
- Random `snk_valid_i` gaps, plus a sop injected mid-packet, plus reset asserted during beat 3. Required:
  - results identical to the gap-free run;
  - aborted packet yields no `hdr_done_o`;
  - outputs 0 after reset.

Source files
------------

// File: rtl/l4_field_extractor.sv
`default_nettype none
// ============================================================================
// Module   : l4_field_extractor
// Purpose  : Passive RX header parser. It skips up to MAX_VLAN VLAN tags and
//            extracts the IP protocol and the L4 ports for the classifier.
// Revision : 1.0
// ============================================================================
module l4_field_extractor #(
    parameter int MAX_VLAN = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] snk_data_i,
    input  logic        snk_valid_i,
    input  logic        snk_sop_i,
    input  logic        snk_eop_i,
    input  logic [2:0]  snk_empty_i,
    output logic [7:0]  ip_prot_o,
    output logic        ip_prot_en_o,
    output logic [15:0] port_src_o,
    output logic        port_src_en_o,
    output logic [15:0] port_dst_o,
    output logic        port_dst_en_o,
    output logic        ipv6_o,
    output logic        hdr_done_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L2   = 3'd1,
        S_IP4  = 3'd2,
        S_IP6  = 3'd3,
        S_L4   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [7:0] C_L3_NO_TAG  = 8'd14;
    localparam logic [7:0] C_L3_ONE_TAG = 8'd18;
    localparam logic [7:0] C_L3_TWO_TAG = 8'd22;

    state_t      r_state, w_state_cur, w_state_nxt;
    logic [3:0]  r_beat_cnt, w_beat;
    logic [7:0]  r_l3_off, w_l3_base, w_l3_tag1, w_l3_off;
    logic [7:0]  r_l4_off, w_l4_nxt;
    logic        w_l4_load;
    logic [7:0]  w_lane_ok;
    logic [15:0] w_etype, w_frag, w_src, w_dst;
    logic [7:0]  w_ver, w_prot;
    logic        r_frag_nz, w_frag_nz, w_frag_cap;
    logic        w_prot_cap, w_src_cap, w_dst_cap, w_ipv6_set, w_done;

    // Byte at absolute offset `off` is carried by the current beat in a valid lane.
    // Every field lives below offset 120, so a saturated counter never matches.
    function automatic logic f_here(input logic [7:0] off, input logic [3:0] beat,
                                    input logic [7:0] lane_ok);
        f_here = (off[7:3] == {1'b0, beat}) && lane_ok[off[2:0]];
    endfunction

    function automatic logic [7:0] f_byte(input logic [63:0] data, input logic [2:0] lane);
        logic [63:0] w_shift;
        w_shift = data << {lane, 3'b000};
        f_byte  = w_shift[63:56];
    endfunction

    // All 16-bit fields start at even offsets, so they never straddle two beats.
    function automatic logic [15:0] f_word(input logic [63:0] data, input logic [7:0] off);
        f_word = {f_byte(data, off[2:0]), f_byte(data, off[2:0] + 3'd1)};
    endfunction

    function automatic logic f_is_tpid(input logic [15:0] w);
        f_is_tpid = (w == 16'h8100) || (w == 16'h88A8);
    endfunction

    function automatic logic f_has_ports(input logic [7:0] p);
        f_has_ports = (p == 8'd6) || (p == 8'd17) || (p == 8'd132);
    endfunction

    always_comb begin
        w_beat      = snk_sop_i ? 4'd0 : ((r_beat_cnt == 4'd15) ? 4'd15 : r_beat_cnt + 4'd1);
        w_state_cur = snk_sop_i ? S_L2 : r_state;
        w_l3_base   = snk_sop_i ? C_L3_NO_TAG : r_l3_off;
        for (int l = 0; l < 8; l++) begin
            w_lane_ok[l] = !snk_eop_i || ((4'(l) + {1'b0, snk_empty_i}) <= 4'd7);
        end
        w_l3_tag1   = w_l3_base;
        w_l3_off    = w_l3_base;
        w_state_nxt = w_state_cur;
        w_l4_load   = 1'b0;
        w_l4_nxt    = r_l4_off;
        w_etype     = 16'h0000;
        w_ver       = 8'h00;
        w_frag      = f_word(snk_data_i, r_l3_off + 8'd6);
        w_frag_cap  = 1'b0;
        w_frag_nz   = r_frag_nz;
        w_prot      = 8'h00;
        w_prot_cap  = 1'b0;
        w_ipv6_set  = 1'b0;
        w_src       = f_word(snk_data_i, r_l4_off);
        w_dst       = f_word(snk_data_i, r_l4_off + 8'd2);
        w_src_cap   = 1'b0;
        w_dst_cap   = 1'b0;

        case (w_state_cur)
            S_L2: begin
                // Tag checks chain within the beat so the EtherType and version
                // byte found behind a tag in the same beat are used immediately.
                if (MAX_VLAN >= 1 && w_l3_base == C_L3_NO_TAG && f_here(8'd13, w_beat, w_lane_ok)
                    && f_is_tpid(f_word(snk_data_i, 8'd12))) begin
                    w_l3_tag1 = C_L3_ONE_TAG;
                end
                w_l3_off = w_l3_tag1;
                if (MAX_VLAN >= 2 && w_l3_tag1 == C_L3_ONE_TAG && f_here(8'd17, w_beat, w_lane_ok)
                    && f_is_tpid(f_word(snk_data_i, 8'd16))) begin
                    w_l3_off = C_L3_TWO_TAG;
                end
                w_etype = f_word(snk_data_i, w_l3_off - 8'd2);
                w_ver   = f_byte(snk_data_i, w_l3_off[2:0]);
                if (f_here(w_l3_off - 8'd1, w_beat, w_lane_ok)) begin
                    if (w_etype == 16'h0800 && f_here(w_l3_off, w_beat, w_lane_ok)
                        && w_ver[7:4] == 4'h4) begin
                        if (w_ver[3:0] < 4'd5) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_IP4;
                            w_l4_load   = 1'b1;
                            w_l4_nxt    = w_l3_off + {2'b00, w_ver[3:0], 2'b00};
                        end
                    end else if (w_etype == 16'h86DD && f_here(w_l3_off, w_beat, w_lane_ok)
                                 && w_ver[7:4] == 4'h6) begin
                        w_state_nxt = S_IP6;
                        w_ipv6_set  = 1'b1;
                        w_l4_load   = 1'b1;
                        w_l4_nxt    = w_l3_off + 8'd40;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_IP4: begin
                if (f_here(r_l3_off + 8'd7, w_beat, w_lane_ok)) begin
                    w_frag_cap = 1'b1;
                    w_frag_nz  = (w_frag & 16'h1FFF) != 16'h0000;
                end
                if (f_here(r_l3_off + 8'd9, w_beat, w_lane_ok)) begin
                    w_prot_cap = 1'b1;
                    w_prot     = f_byte(snk_data_i, r_l3_off[2:0] + 3'd1);
                    w_state_nxt = (!w_frag_nz && f_has_ports(w_prot)) ? S_L4 : S_DONE;
                end
            end
            S_IP6: begin
                if (f_here(r_l3_off + 8'd6, w_beat, w_lane_ok)) begin
                    w_prot_cap  = 1'b1;
                    w_prot      = f_byte(snk_data_i, r_l3_off[2:0] + 3'd6);
                    w_state_nxt = f_has_ports(w_prot) ? S_L4 : S_DONE;
                end
            end
            S_L4: begin
                w_src_cap = f_here(r_l4_off + 8'd1, w_beat, w_lane_ok);
                w_dst_cap = f_here(r_l4_off + 8'd3, w_beat, w_lane_ok);
                if ((port_src_en_o || w_src_cap) && (port_dst_en_o || w_dst_cap)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: ;
        endcase

        w_done = (w_state_cur == S_L2 || w_state_cur == S_IP4 || w_state_cur == S_IP6
                  || w_state_cur == S_L4) && (w_state_nxt == S_DONE || snk_eop_i);
        if (snk_eop_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_beat_cnt    <= 4'd0;
            r_l3_off      <= C_L3_NO_TAG;
            r_l4_off      <= 8'd0;
            r_frag_nz     <= 1'b0;
            ip_prot_o     <= 8'd0;
            ip_prot_en_o  <= 1'b0;
            port_src_o    <= 16'd0;
            port_src_en_o <= 1'b0;
            port_dst_o    <= 16'd0;
            port_dst_en_o <= 1'b0;
            ipv6_o        <= 1'b0;
            hdr_done_o    <= 1'b0;
        end else begin
            hdr_done_o <= 1'b0;
            if (snk_valid_i) begin
                r_state    <= w_state_nxt;
                r_beat_cnt <= w_beat;
                r_l3_off   <= w_l3_off;
                hdr_done_o <= w_done;
                if (w_l4_load) begin
                    r_l4_off <= w_l4_nxt;
                end
                if (snk_sop_i) begin
                    ip_prot_en_o  <= 1'b0;
                    port_src_en_o <= 1'b0;
                    port_dst_en_o <= 1'b0;
                    ipv6_o        <= 1'b0;
                    r_frag_nz     <= 1'b0;
                end
                if (w_ipv6_set) begin
                    ipv6_o <= 1'b1;
                end
                if (w_frag_cap) begin
                    r_frag_nz <= w_frag_nz;
                end
                if (w_prot_cap) begin
                    ip_prot_o    <= w_prot;
                    ip_prot_en_o <= 1'b1;
                end
                if (w_src_cap) begin
                    port_src_o    <= w_src;
                    port_src_en_o <= 1'b1;
                end
                if (w_dst_cap) begin
                    port_dst_o    <= w_dst;
                    port_dst_en_o <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l4_field_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_l4_field_extractor
// Purpose  : Directed self-checking bench for l4_field_extractor.
// Revision : 1.0
// ============================================================================
module tb_l4_field_extractor;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [63:0] snk_data_i = 64'd0;
    logic        snk_valid_i = 1'b0;
    logic        snk_sop_i = 1'b0;
    logic        snk_eop_i = 1'b0;
    logic [2:0]  snk_empty_i = 3'd0;
    logic [7:0]  ip_prot_o;
    logic        ip_prot_en_o;
    logic [15:0] port_src_o;
    logic        port_src_en_o;
    logic [15:0] port_dst_o;
    logic        port_dst_en_o;
    logic        ipv6_o;
    logic        hdr_done_o;

    always #5 clk = ~clk;

    l4_field_extractor #(.MAX_VLAN(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .snk_data_i    (snk_data_i),
        .snk_valid_i   (snk_valid_i),
        .snk_sop_i     (snk_sop_i),
        .snk_eop_i     (snk_eop_i),
        .snk_empty_i   (snk_empty_i),
        .ip_prot_o     (ip_prot_o),
        .ip_prot_en_o  (ip_prot_en_o),
        .port_src_o    (port_src_o),
        .port_src_en_o (port_src_en_o),
        .port_dst_o    (port_dst_o),
        .port_dst_en_o (port_dst_en_o),
        .ipv6_o        (ipv6_o),
        .hdr_done_o    (hdr_done_o)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] pkt [0:127];
    int         done_cnt;
    int         prot_beat;
    int         port_beat;
    logic [3:0] en_b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {19'd0, ip_prot_o, ip_prot_en_o, port_src_o, port_src_en_o,
                port_dst_o, port_dst_en_o, ipv6_o, hdr_done_o};
    endfunction

    task automatic clear_pkt();
        for (int i = 0; i < 128; i++) pkt[i] = (i < 12) ? 8'(8'hA0 + i) : 8'h00;
    endtask

    task automatic put16(input int off, input logic [15:0] v);
        pkt[off]     = v[15:8];
        pkt[off + 1] = v[7:0];
    endtask

    task automatic build_v4(input int ntags, input logic [3:0] ihl, input logic [15:0] frag,
                            input logic [7:0] proto, input logic [15:0] src, input logic [15:0] dst);
        int l3;
        int l4;
        clear_pkt();
        if (ntags == 2) begin
            put16(12, 16'h88A8);
            put16(16, 16'h8100);
            l3 = 22;
        end else begin
            l3 = 14;
        end
        put16(l3 - 2, 16'h0800);
        pkt[l3]     = {4'h4, ihl};
        put16(l3 + 6, frag);
        pkt[l3 + 9] = proto;
        l4 = l3 + 4 * int'(ihl);
        put16(l4, src);
        put16(l4 + 2, dst);
    endtask

    task automatic build_v6(input logic [7:0] nh, input logic [15:0] src, input logic [15:0] dst);
        clear_pkt();
        put16(12, 16'h86DD);
        pkt[14] = 8'h60;
        pkt[20] = nh;
        put16(54, src);
        put16(56, dst);
    endtask

    task automatic sample(input int b);
        if (hdr_done_o) done_cnt++;
        if (ip_prot_en_o && prot_beat < 0) prot_beat = b;
        if (port_src_en_o && port_dst_en_o && port_beat < 0) port_beat = b;
    endtask

    // Sends `len` bytes of pkt, stopping after `max_beats` (no eop if cut short).
    task automatic send(input int len, input int max_beats, input bit gaps, input int rst_beat);
        int nb;
        int sent;
        int g;
        nb = (len + 7) / 8;
        sent = (max_beats < nb) ? max_beats : nb;
        done_cnt = 0;
        prot_beat = -1;
        port_beat = -1;
        for (int b = 0; b < sent; b++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                @(negedge clk);
                snk_valid_i = 1'b0;
                snk_data_i  = {$urandom, $urandom};
                snk_sop_i   = 1'($urandom_range(0, 1));
                snk_eop_i   = 1'($urandom_range(0, 1));
                snk_empty_i = 3'($urandom_range(0, 7));
                rst_i       = 1'b0;
                @(posedge clk);
                #1 sample(b);
            end
            @(negedge clk);
            snk_valid_i = 1'b1;
            snk_sop_i   = (b == 0);
            snk_eop_i   = (b == nb - 1);
            snk_empty_i = (b == nb - 1) ? 3'(nb * 8 - len) : 3'd0;
            for (int k = 0; k < 8; k++) begin
                snk_data_i[63 - 8 * k -: 8] = (b * 8 + k < len) ? pkt[b * 8 + k] : 8'hEE;
            end
            rst_i = (b == rst_beat);
            @(posedge clk);
            #1 sample(b);
            if (b == 0) en_b0 = {ip_prot_en_o, port_src_en_o, port_dst_en_o, ipv6_o};
            if (b == rst_beat) chk("rst_mid_outputs", outs(), 64'd0);
        end
        @(negedge clk);
        snk_valid_i = 1'b0;
        snk_sop_i   = 1'b0;
        snk_eop_i   = 1'b0;
        rst_i       = 1'b0;
    endtask

    task automatic check_t1(input string tag);
        chk({tag, "_prot"}, {ip_prot_en_o, ip_prot_o}, {1'b1, 8'd6});
        chk({tag, "_prot_beat"}, prot_beat, 2);
        chk({tag, "_src"}, {port_src_en_o, port_src_o}, {1'b1, 16'h1F90});
        chk({tag, "_dst"}, {port_dst_en_o, port_dst_o}, {1'b1, 16'h0017});
        chk({tag, "_port_beat"}, port_beat, 4);
        chk({tag, "_ipv6"}, ipv6_o, 1'b0);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs(), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Untagged IPv4 TCP; DF bit set must not read as a fragment
        build_v4(0, 4'd5, 16'h4000, 8'd6, 16'h1F90, 16'h0017);
        send(60, 99, 1'b0, -1);
        check_t1("t1");

        // Double-tagged IPv4 UDP, IHL=7: l3_off 22, l4_off 50 (beat 6)
        build_v4(2, 4'd7, 16'h0000, 8'd17, 16'h0140, 16'd319);
        send(64, 99, 1'b0, -1);
        chk("t2_prot", {ip_prot_en_o, ip_prot_o}, {1'b1, 8'd17});
        chk("t2_ports", {port_src_en_o, port_src_o, port_dst_en_o, port_dst_o},
            {1'b1, 16'h0140, 1'b1, 16'd319});
        chk("t2_port_beat", port_beat, 6);
        chk("t2_done", done_cnt, 1);

        // IPv6 UDP, ports straddle beats 6 and 7
        build_v6(8'd17, 16'hC000, 16'd53);
        send(70, 99, 1'b0, -1);
        chk("t3_ipv6", ipv6_o, 1'b1);
        chk("t3_prot", {ip_prot_en_o, ip_prot_o}, {1'b1, 8'd17});
        chk("t3_ports", {port_src_en_o, port_src_o, port_dst_en_o, port_dst_o},
            {1'b1, 16'hC000, 1'b1, 16'd53});
        chk("t3_done", done_cnt, 1);

        // IPv4 fragment: protocol only
        build_v4(0, 4'd5, 16'h00B9, 8'd17, 16'h1111, 16'h2222);
        send(60, 99, 1'b0, -1);
        chk("t4_prot", {ip_prot_en_o, ip_prot_o}, {1'b1, 8'd17});
        chk("t4_port_en", {port_src_en_o, port_dst_en_o}, 2'b00);
        chk("t4_done", done_cnt, 1);

        // ARP
        clear_pkt();
        put16(12, 16'h0806);
        send(42, 99, 1'b0, -1);
        chk("t5_arp_en", {ip_prot_en_o, port_src_en_o, port_dst_en_o, ipv6_o}, 4'b0000);
        chk("t5_arp_done", done_cnt, 1);

        // 30-byte IPv4 truncated by eop before the ports
        build_v4(0, 4'd5, 16'h0000, 8'd6, 16'h1F90, 16'h0017);
        send(30, 99, 1'b0, -1);
        chk("t5_trunc_prot", {ip_prot_en_o, ip_prot_o}, {1'b1, 8'd6});
        chk("t5_trunc_port_en", {port_src_en_o, port_dst_en_o}, 2'b00);
        chk("t5_trunc_done", done_cnt, 1);

        // 36 bytes: src fits exactly in the valid lanes, dst falls in empty
        send(36, 99, 1'b0, -1);
        chk("t5_empty_src", {port_src_en_o, port_src_o}, {1'b1, 16'h1F90});
        chk("t5_empty_dst_en", port_dst_en_o, 1'b0);
        chk("t5_empty_done", done_cnt, 1);

        // Single-beat packet
        send(8, 99, 1'b0, -1);
        chk("t5_single_en", {ip_prot_en_o, port_src_en_o, port_dst_en_o, ipv6_o}, 4'b0000);
        chk("t5_single_done", done_cnt, 1);

        // Gap-ridden repeat of the first packet
        build_v4(0, 4'd5, 16'h4000, 8'd6, 16'h1F90, 16'h0017);
        send(60, 99, 1'b1, -1);
        check_t1("t6_gaps");

        // Aborted packet (3 beats, protocol already captured), then an IPv6 sop
        send(60, 3, 1'b1, -1);
        chk("t6_abort_prot_en", ip_prot_en_o, 1'b1);
        chk("t6_abort_done", done_cnt, 0);
        build_v6(8'd17, 16'hC000, 16'd53);
        send(70, 99, 1'b1, -1);
        chk("t6_sop_clears_en", en_b0, 4'b0000);
        chk("t6_after_abort", {ipv6_o, ip_prot_o, port_dst_o}, {1'b1, 8'd17, 16'd53});
        chk("t6_after_abort_done", done_cnt, 1);

        // Reset during beat 3, remaining beats ignored
        build_v4(0, 4'd5, 16'h4000, 8'd6, 16'h1F90, 16'h0017);
        send(60, 99, 1'b0, 3);
        chk("t6_rst_done", done_cnt, 0);
        chk("t6_rst_after", outs(), 64'd0);
        send(60, 99, 1'b0, -1);
        check_t1("t6_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
